// File: rtl/fp_pkg.sv
// Shared FP multiply-array constants and types.
// Used by the result serializer and the input distributor.
package fp_pkg;

  localparam int FP_W       = 32;
  localparam int FP_LANES   = 16;
  localparam int FP_LANE_W  = $clog2(FP_LANES);
  localparam int FP_NUM_RES = FP_LANES / 2;

  typedef logic [FP_LANE_W-1:0] lane_idx_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  // result_k (k = 1..FP_NUM_RES): A in lane 2k-2, B in lane 2k-1
  function automatic lane_idx_t lane_of_a(input int k);
    return lane_idx_t'(2 * k - 2);
  endfunction

  function automatic lane_idx_t lane_of_b(input int k);
    return lane_idx_t'(2 * k - 1);
  endfunction

  localparam lane_idx_t RES_FIRST_A = lane_of_a(1);
  localparam lane_idx_t RES_LAST_B  = lane_of_b(FP_NUM_RES);

endpackage

// File: rtl/fp_batch_slot.sv
// One batch of LANES products plus its accumulate tag.
// Load wins over clear; clear only drops tag and full flag.
module fp_batch_slot
  import fp_pkg::*;
#(
  parameter int DW    = FP_W,
  parameter int LANES = FP_LANES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic [DW*LANES-1:0] d_data,
  input  logic                d_tag,
  output logic [DW*LANES-1:0] q_data,
  output logic                q_tag,
  output logic                full
);

  logic [DW*LANES-1:0] data_q, data_d;
  logic                tag_q, tag_d;
  logic                full_q, full_d;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    full_d = full_q;
    if (load) begin
      data_d = d_data;
      tag_d  = d_tag;
      full_d = 1'b1;
    end else if (clear) begin
      tag_d  = 1'b0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      tag_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      full_q <= full_d;
    end
  end

  assign q_data = data_q;
  assign q_tag  = tag_q;
  assign full   = full_q;

endmodule

// File: rtl/fp_result_serializer.sv
// Parallel-to-serial return path of the FP multiply array.
// ACT slot streams one lane per handshake; PEND slot buffers the next batch.
module fp_result_serializer
  import fp_pkg::*;
#(
  parameter int DW    = FP_W,
  parameter int LANES = FP_LANES
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DW*LANES-1:0] in_results,
  input  logic                in_capture,
  input  logic                in_acc_sign,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                out_acc_sign,
  output logic                cap_ready,
  output logic                overflow
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

  ser_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          overflow_q, overflow_d;

  logic                act_ld, act_clr, act_src_pend;
  logic                pend_ld, pend_clr;
  logic [DW*LANES-1:0] act_data, pend_data, act_d_data;
  logic                act_tag, pend_tag, act_d_tag;
  logic                act_full, pend_full;
  logic                hs, last_hs;

  logic [DW-1:0] act_w [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign act_w[l] = act_data[DW*l +: DW];
  end

  assign act_d_data = act_src_pend ? pend_data : in_results;
  assign act_d_tag  = act_src_pend ? pend_tag : in_acc_sign;

  fp_batch_slot #(.DW(DW), .LANES(LANES)) u_act (
    .clk    (aclk),
    .rst_n  (aresetn),
    .load   (act_ld),
    .clear  (act_clr),
    .d_data (act_d_data),
    .d_tag  (act_d_tag),
    .q_data (act_data),
    .q_tag  (act_tag),
    .full   (act_full)
  );

  fp_batch_slot #(.DW(DW), .LANES(LANES)) u_pend (
    .clk    (aclk),
    .rst_n  (aresetn),
    .load   (pend_ld),
    .clear  (pend_clr),
    .d_data (in_results),
    .d_tag  (in_acc_sign),
    .q_data (pend_data),
    .q_tag  (pend_tag),
    .full   (pend_full)
  );

  assign hs      = out_valid & out_ready;
  assign last_hs = hs & (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    overflow_d   = overflow_q;
    act_ld       = 1'b0;
    act_clr      = 1'b0;
    act_src_pend = 1'b0;
    pend_ld      = 1'b0;
    pend_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_capture) begin
          act_ld     = 1'b1;
          state_d    = S_SEND;
          cnt_d      = '0;
          out_data_d = in_results[DW-1:0];
          out_last_d = 1'b0;
        end
      end
      S_SEND: begin
        if (last_hs) begin
          cnt_d      = '0;
          out_last_d = 1'b0;
          if (pend_full) begin
            // back-to-back batch: PEND refills from a same-cycle capture
            act_ld       = 1'b1;
            act_src_pend = 1'b1;
            out_data_d   = pend_data[DW-1:0];
            pend_ld      = in_capture;
            pend_clr     = ~in_capture;
          end else if (in_capture) begin
            act_ld     = 1'b1;
            out_data_d = in_results[DW-1:0];
          end else begin
            act_clr    = 1'b1;
            state_d    = S_IDLE;
            out_data_d = '0;
          end
        end else begin
          if (hs) begin
            cnt_d      = cnt_q + 1'b1;
            out_data_d = act_w[cnt_d];
            out_last_d = (cnt_d == CNT_LAST);
          end
          if (in_capture) begin
            if (pend_full) overflow_d = 1'b1;
            else           pend_ld    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign out_valid    = (state_q == S_SEND) & act_full;
  assign out_acc_sign = act_tag;
  // gated so every output reads 0 while reset is held
  assign cap_ready    = aresetn & ~pend_full;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_fp_result_serializer.sv
// Scoreboard bench for fp_result_serializer.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_fp_result_serializer;

  localparam int DW = 32;
  localparam int LN = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic          tag;
  } beat_t;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [DW*LN-1:0] in_results;
  logic             in_capture;
  logic             in_acc_sign;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             out_acc_sign;
  logic             cap_ready;
  logic             overflow;

  beat_t sb[$];
  int nvec  = 0;
  int nfail = 0;

  always #5 aclk = ~aclk;

  fp_result_serializer #(.DW(DW), .LANES(LN)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .in_results   (in_results),
    .in_capture   (in_capture),
    .in_acc_sign  (in_acc_sign),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_acc_sign (out_acc_sign),
    .cap_ready    (cap_ready),
    .overflow     (overflow)
  );

  always @(negedge aclk) begin
    if (aresetn && out_valid) begin
      nvec++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_beat got data=%h last=%b tag=%b",
                 out_data, out_last, out_acc_sign);
      end else begin
        if ({out_data, out_last, out_acc_sign} !== sb[0]) begin
          nfail++;
          $display("FAIL %s_beat got %h/%b/%b want %h/%b/%b",
                   out_ready ? "accept" : "stall",
                   out_data, out_last, out_acc_sign,
                   sb[0].d, sb[0].last, sb[0].tag);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic cap(input logic [31:0] base, input logic tag,
                     input bit expect_out);
    for (int i = 0; i < LN; i++) begin
      in_results[DW*i +: DW] = base + 32'(i);
      if (expect_out) sb.push_back('{base + 32'(i), i == LN - 1, tag});
    end
    in_acc_sign = tag;
    in_capture  = 1'b1;
    tick();
    in_capture  = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_data"},  out_data, 32'h0);
    chk({nm, "_valid"}, 32'(out_valid), 32'h0);
    chk({nm, "_last"},  32'(out_last), 32'h0);
    chk({nm, "_tag"},   32'(out_acc_sign), 32'h0);
    chk({nm, "_crdy"},  32'(cap_ready), 32'h0);
    chk({nm, "_ovf"},   32'(overflow), 32'h0);
  endtask

  initial begin
    int n;
    aresetn     = 1'b1;
    in_results  = '0;
    in_capture  = 1'b0;
    in_acc_sign = 1'b0;
    out_ready   = 1'b1;
    #2 aresetn  = 1'b0;
    tick();
    chk_zero("reset");
    tick();
    aresetn = 1'b1;
    tick();
    chk("crdy_after_reset", 32'(cap_ready), 32'h1);

    // 1: single batch, full throughput
    cap(32'h3F80_0000, 1'b1, 1'b1);
    chk("t1_latency_valid", 32'(out_valid), 32'h1);
    drain(n);
    chk("t1_beat_cycles", n, 16);
    chk("t1_idle_valid", 32'(out_valid), 32'h0);

    // 2: out_ready toggling
    cap(32'h3F80_0000, 1'b1, 1'b1);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    chk("t2_drained", sb.size(), 0);
    out_ready = 1'b1;
    tick();

    // 3: second capture at beat 5, no gap between batches
    cap(32'hA000_0000, 1'b0, 1'b1);
    repeat (4) tick();
    cap(32'hB000_0000, 1'b1, 1'b1);
    chk("t3_crdy_full", 32'(cap_ready), 32'h0);
    drain(n);
    chk("t3_beat_cycles", n, 27);
    chk("t3_crdy_free", 32'(cap_ready), 32'h1);
    tick();

    // 5: capture on the last handshake with PEND empty
    cap(32'hC000_0000, 1'b0, 1'b1);
    repeat (15) tick();
    cap(32'hD000_0000, 1'b1, 1'b1);
    chk("t5_valid_next", 32'(out_valid), 32'h1);
    chk("t5_lane0", out_data, 32'hD000_0000);
    drain(n);
    chk("t5_beat_cycles", n, 16);
    chk("t5_ovf", 32'(overflow), 32'h0);
    tick();

    // 4: third capture while PEND full is dropped
    cap(32'h1000_0000, 1'b1, 1'b1);
    repeat (2) tick();
    cap(32'h2000_0000, 1'b0, 1'b1);
    repeat (2) tick();
    cap(32'h3000_0000, 1'b1, 1'b0);
    chk("t4_ovf_set", 32'(overflow), 32'h1);
    chk("t4_crdy", 32'(cap_ready), 32'h0);
    drain(n);
    chk("t4_beat_cycles", n, 26);
    repeat (3) tick();
    chk("t4_no_third", 32'(out_valid), 32'h0);
    chk("t4_ovf_sticky", 32'(overflow), 32'h1);

    // 6: reset mid-batch, then a clean batch
    cap(32'h4000_0000, 1'b1, 1'b1);
    repeat (6) tick();
    aresetn = 1'b0;
    sb.delete();
    #1;
    chk_zero("t6_rst");
    tick();
    chk_zero("t6_rst_hold");
    aresetn = 1'b1;
    tick();
    cap(32'h5000_0000, 1'b0, 1'b1);
    drain(n);
    chk("t6_beat_cycles", n, 16);
    chk("t6_ovf", 32'(overflow), 32'h0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
